// File: rtl/ysyx_23060240_axi_rd_arbiter.sv
// 2:1 AXI4-Lite read-channel arbiter sharing one SRAM read port between IFU (m0) and LSU (m1).
// One transaction in flight; round-robin on ties, arbitration only while idle.
module ysyx_23060240_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,

    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;   // 0 = m0 won last, 1 = m1 won last
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pick_m0, pick_m1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_gnt_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
        end
    end

    // m1 wins a tie only when m0 was the previous winner
    assign pick_m1 = m1_arvalid && (!m0_arvalid || !last_gnt_q);
    assign pick_m0 = m0_arvalid && !pick_m1;
    assign gnt     = gnt_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        s_araddr   = addr_q;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;

        case (state_q)
            IDLE: begin
                m0_arready = pick_m0;
                m1_arready = pick_m1;
                if (pick_m0 || pick_m1) begin
                    addr_d     = pick_m1 ? m1_araddr : m0_araddr;
                    gnt_d      = {pick_m1, pick_m0};
                    last_gnt_d = pick_m1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (gnt_q[0]) begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    s_rready  = m0_rready;
                end else if (gnt_q[1]) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    s_rready  = m1_rready;
                end
                if (s_rvalid && s_rready) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060240_axi_rd_arbiter.sv
// Directed bench for the 2:1 read arbiter: bench-side SRAM responder plus IFU/LSU requesters.
module tb_ysyx_23060240_axi_rd_arbiter;

    logic        clk, rst;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp, gnt;
    logic        m0_rvalid, m0_rready, m1_rvalid, m1_rready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;

    ysyx_23060240_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .gnt(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // requester / responder controls
    logic        req0_pend = 0, req1_pend = 0;
    logic [31:0] req0_addr = 0, req1_addr = 0;
    int          re0_left = 0, re1_left = 0, stall0 = 0, stall1 = 0;
    int          ar_wait = 0, r_wait = 0, ar_cnt = 0, r_cnt = 0, sl_phase = 0;
    logic [31:0] slv_data = 0;
    logic [1:0]  slv_resp = 0;

    // observations
    logic [31:0] ar_log[$];
    int          gnt_log[$], hs_cyc[$], rhs_cyc[$], arhs_cyc[$];
    int          cyc_n = 0, rcnt0 = 0, rcnt1 = 0, m1_rv_seen = 0, ar_starts = 0, unstable = 0;
    logic [31:0] last_rdata0 = 0, last_rdata1 = 0, arv_addr = 0;
    logic [1:0]  last_rresp0 = 0, last_rresp1 = 0, gnt_at_r = 0;
    logic        arv_prev = 0;

    always begin
        logic hs0, hs1, ar_hs, r_hs, rh0, rh1;
        logic [31:0] sa, d0, d1;
        logic [1:0]  p0, p1, g;
        @(negedge clk);
        m0_arvalid = req0_pend; m0_araddr = req0_addr;
        m1_arvalid = req1_pend; m1_araddr = req1_addr;
        if (!rst) begin
            s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
            sl_phase = 0; ar_cnt = 0; r_cnt = 0;
        end else if (sl_phase == 0) begin
            s_rvalid = 0; s_rdata = 0; s_rresp = 0;
            if (s_arvalid && ar_cnt >= ar_wait) s_arready = 1;
            else begin
                s_arready = 0;
                if (s_arvalid) ar_cnt++;
            end
        end else begin
            s_arready = 0;
            if (r_cnt >= r_wait) begin
                s_rvalid = 1; s_rdata = slv_data; s_rresp = slv_resp;
            end else r_cnt++;
        end
        #1;
        m0_rready = !(m0_rvalid && stall0 > 0);
        if (m0_rvalid && stall0 > 0) stall0--;
        m1_rready = !(m1_rvalid && stall1 > 0);
        if (m1_rvalid && stall1 > 0) stall1--;
        #1;
        hs0 = m0_arvalid && m0_arready;  hs1 = m1_arvalid && m1_arready;
        ar_hs = s_arvalid && s_arready;  r_hs = s_rvalid && s_rready;
        rh0 = m0_rvalid && m0_rready;    rh1 = m1_rvalid && m1_rready;
        sa = s_araddr; d0 = m0_rdata; d1 = m1_rdata; p0 = m0_rresp; p1 = m1_rresp; g = gnt;
        if (m1_rvalid) m1_rv_seen++;
        if (s_arvalid && !arv_prev) begin ar_starts++; arv_addr = s_araddr; end
        else if (s_arvalid && s_araddr !== arv_addr) unstable++;
        arv_prev = s_arvalid;
        @(posedge clk);
        if (rst) begin
            cyc_n++;
            if (hs0) begin
                gnt_log.push_back(0); hs_cyc.push_back(cyc_n);
                if (re0_left > 0) begin re0_left--; req0_addr += 4; end else req0_pend = 0;
            end
            if (hs1) begin
                gnt_log.push_back(1); hs_cyc.push_back(cyc_n);
                if (re1_left > 0) begin re1_left--; req1_addr += 4; end else req1_pend = 0;
            end
            if (ar_hs) begin ar_log.push_back(sa); arhs_cyc.push_back(cyc_n); sl_phase = 1; r_cnt = 0; end
            if (r_hs) begin rhs_cyc.push_back(cyc_n); sl_phase = 0; ar_cnt = 0; gnt_at_r = g; end
            if (rh0) begin rcnt0++; last_rdata0 = d0; last_rresp0 = p0; end
            if (rh1) begin rcnt1++; last_rdata1 = d1; last_rresp1 = p1; end
        end
    end

    task automatic step();
        @(negedge clk); #3;
    endtask

    task automatic wait_r(input int which, input int target, input string tag);
        for (int i = 0; i < 200; i++) begin
            if ((which == 1 ? rcnt1 : rcnt0) >= target) break;
            step();
        end
        check_val(tag, which == 1 ? rcnt1 : rcnt0, target);
    endtask

    task automatic wait_gnt(input logic [1:0] g, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (gnt == g) break;
            step();
        end
        check_val(tag, gnt, g);
    endtask

    task automatic clear_logs();
        ar_log.delete(); gnt_log.delete(); hs_cyc.delete(); rhs_cyc.delete(); arhs_cyc.delete();
    endtask

    initial begin
        int s0, s1, a0;
        rst = 0;
        m0_arvalid = 0; m1_arvalid = 0; m0_araddr = 0; m1_araddr = 0;
        m0_rready = 1; m1_rready = 1;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        #2;
        check_val("rst_gnt", gnt, 2'b00);
        check_val("rst_s_arvalid", s_arvalid, 0);
        check_val("rst_s_rready", s_rready, 0);
        check_val("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        check_val("rst_s_araddr", s_araddr, 32'h0);
        repeat (2) step();
        rst = 1;
        step();

        // single IFU read
        m1_rv_seen = 0; clear_logs();
        slv_data = 32'h0000_0413; slv_resp = 0;
        req0_addr = 32'h8000_0000; req0_pend = 1;
        wait_r(0, 1, "ifu_done");
        check_val("ifu_rdata", last_rdata0, 32'h0000_0413);
        check_val("ifu_rresp", last_rresp0, 2'b00);
        check_val("ifu_gnt", gnt_at_r, 2'b01);
        check_val("ifu_m1_rvalid", m1_rv_seen, 0);
        check_val("ifu_ar_latency", (arhs_cyc.size() > 0 && hs_cyc.size() > 0) ? arhs_cyc[0] - hs_cyc[0] : -1, 1);
        step();
        check_val("ifu_gnt_idle", gnt, 2'b00);

        // tie: last winner was m0, so m1 goes first
        clear_logs(); s0 = rcnt0; s1 = rcnt1;
        slv_data = 32'h1234_5678;
        req0_addr = 32'h8000_0004; req1_addr = 32'h8000_1000;
        req0_pend = 1; req1_pend = 1;
        wait_r(0, s0 + 1, "tie_m0_done");
        wait_r(1, s1 + 1, "tie_m1_done");
        check_val("tie_ar_count", ar_log.size(), 2);
        if (ar_log.size() >= 2) begin
            check_val("tie_araddr0", ar_log[0], 32'h8000_1000);
            check_val("tie_araddr1", ar_log[1], 32'h8000_0004);
        end
        if (gnt_log.size() >= 2) check_val("tie_order", {gnt_log[0][1:0], gnt_log[1][1:0]}, 4'b0100);

        // four continuous ties: m1, m0, m1, m0 with one idle cycle between
        step(); clear_logs(); s0 = rcnt0; s1 = rcnt1;
        req0_addr = 32'h8000_0100; req1_addr = 32'h8000_2100;
        re0_left = 1; re1_left = 1; req0_pend = 1; req1_pend = 1;
        wait_r(0, s0 + 2, "rr_m0_done");
        wait_r(1, s1 + 2, "rr_m1_done");
        check_val("rr_txn_count", gnt_log.size(), 4);
        if (gnt_log.size() >= 4)
            check_val("rr_order", {gnt_log[0][1:0], gnt_log[1][1:0], gnt_log[2][1:0], gnt_log[3][1:0]},
                      8'b01_00_01_00);
        if (hs_cyc.size() >= 4 && rhs_cyc.size() >= 3)
            for (int k = 0; k < 3; k++) check_val("rr_idle_gap", hs_cyc[k+1] - rhs_cyc[k], 1);

        // slave stall with LSU back-pressure; m0 arrives mid-transaction and must wait
        step(); clear_logs(); s0 = rcnt0; s1 = rcnt1; a0 = ar_starts; unstable = 0;
        ar_wait = 3; r_wait = 5; stall1 = 2; slv_data = 32'h0BAD_F00D;
        req1_addr = 32'h8000_2000; req1_pend = 1;
        wait_gnt(2'b10, "stall_gnt_m1");
        req0_addr = 32'h8000_0020; req0_pend = 1;
        step(); step();
        check_val("stall_m0_arready_held", m0_arready, 0);
        check_val("stall_s_araddr", s_araddr, 32'h8000_2000);
        wait_r(1, s1 + 1, "stall_m1_done");
        check_val("stall_rdata", last_rdata1, 32'h0BAD_F00D);
        check_val("stall_ar_starts", ar_starts - a0, 1);
        check_val("stall_araddr_stable", unstable, 0);
        check_val("stall_r_latency", (rhs_cyc.size() > 0 && arhs_cyc.size() > 0) ? rhs_cyc[0] - arhs_cyc[0] : -1, 8);
        ar_wait = 0; r_wait = 0; slv_data = 32'h0000_CAFE;
        wait_r(0, s0 + 1, "stall_m0_after");
        check_val("stall_m0_rdata", last_rdata0, 32'h0000_CAFE);
        repeat (3) step();
        check_val("stall_m1_once", rcnt1, s1 + 1);

        // SLVERR propagated to LSU
        clear_logs(); s1 = rcnt1;
        slv_data = 32'hDEAD_BEEF; slv_resp = 2'b10;
        req1_addr = 32'h8000_3000; req1_pend = 1;
        wait_r(1, s1 + 1, "err_done");
        check_val("err_rresp", last_rresp1, 2'b10);
        check_val("err_rdata", last_rdata1, 32'hDEAD_BEEF);
        check_val("err_idle_gnt", gnt, 2'b00);
        slv_resp = 0;

        // reset while a read is pending in DATA
        clear_logs(); s0 = rcnt0;
        r_wait = 20; slv_data = 32'h5555_5555;
        req0_addr = 32'h8000_0030; req0_pend = 1;
        for (int i = 0; i < 50; i++) begin
            if (gnt == 2'b01 && s_rready) break;
            step();
        end
        check_val("rstd_in_data", s_rready, 1);
        rst = 0; req0_pend = 0;
        #1;
        check_val("rstd_gnt", gnt, 2'b00);
        check_val("rstd_s_rready", s_rready, 0);
        check_val("rstd_s_arvalid", s_arvalid, 0);
        check_val("rstd_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        repeat (2) step();
        rst = 1; r_wait = 0; slv_data = 32'h1122_3344;
        req0_addr = 32'h8000_0040; req0_pend = 1;
        wait_r(0, s0 + 1, "rstd_fresh_done");
        check_val("rstd_fresh_rdata", last_rdata0, 32'h1122_3344);
        check_val("rstd_fresh_araddr", ar_log.size() > 0 ? ar_log[ar_log.size()-1] : 32'hFFFF_FFFF, 32'h8000_0040);

        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
